icache: RTL

ICACHE -- requirements
Module: icache

---
 rtl/icache_pkg.sv | 24 ++
 rtl/icache_if.sv | 27 ++
 rtl/icache_array.sv | 60 ++++++
 rtl/icache.sv | 134 +++++++++++++
 4 files changed

// File: rtl/icache_pkg.sv
// Shared types and address-field widths for the direct-mapped instruction cache.
// Field widths here describe the default 64-line, 4-word geometry.
package icache_pkg;

   localparam int ADDR_W   = 36;
   localparam int INSTR_W  = 32;
   localparam int WORDS    = 4;
   localparam int OFFSET_W = 2;
   localparam int LINE_LSB = 4;
   localparam int INDEX_W  = 6;
   localparam int TAG_W    = ADDR_W - LINE_LSB - INDEX_W;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_REQ,
      ST_FILL,
      ST_DONE
   } state_t;

   function automatic logic [ADDR_W-1:0] line_align(input logic [ADDR_W-1:0] addr);
      return {addr[ADDR_W-1:LINE_LSB], {LINE_LSB{1'b0}}};
   endfunction

endpackage

// File: rtl/icache_if.sv
// Line-fill memory bus between the icache (master) and the next memory level (slave).
interface icache_if;
   import icache_pkg::*;

   logic              mem_req;
   logic [ADDR_W-1:0] mem_addr;
   logic              mem_gnt;
   logic              mem_rvalid;
   logic [INSTR_W-1:0] mem_rdata;

   modport master (
      output mem_req,
      output mem_addr,
      input  mem_gnt,
      input  mem_rvalid,
      input  mem_rdata
   );

   modport slave (
      input  mem_req,
      input  mem_addr,
      output mem_gnt,
      output mem_rvalid,
      output mem_rdata
   );

endinterface

// File: rtl/icache_array.sv
// Valid/tag/data storage: combinational read for zero-latency lookup, synchronous write.
// Only the valid bits are reset; tag and data contents are meaningless until validated.
module icache_array
   import icache_pkg::*;
#(
   parameter int LINES   = 64,
   parameter int WORDS_P = 4,
   parameter int IDX_W   = 6,
   parameter int TAG_WD  = 26,
   parameter int WORD_W  = $clog2(WORDS_P)
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [IDX_W-1:0]   rd_index,
   input  logic [WORD_W-1:0]  rd_offset,
   output logic               rd_valid,
   output logic [TAG_WD-1:0]  rd_tag,
   output logic [INSTR_W-1:0] rd_data,
   input  logic               clear_all,
   input  logic [IDX_W-1:0]   wr_index,
   input  logic               data_we,
   input  logic [WORD_W-1:0]  wr_word,
   input  logic [INSTR_W-1:0] wr_data,
   input  logic               tag_we,
   input  logic [TAG_WD-1:0]  wr_tag,
   input  logic               set_valid
);

   logic [LINES-1:0]   valid_reg;
   logic [TAG_WD-1:0]  tag_mem  [LINES];
   logic [INSTR_W-1:0] data_mem [LINES*WORDS_P];

   // A flush in the same cycle as a validate must win, so clear_all has priority.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         valid_reg <= '0;
      end else if (clear_all) begin
         valid_reg <= '0;
      end else if (set_valid) begin
         valid_reg[wr_index] <= 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (tag_we) begin
         tag_mem[wr_index] <= wr_tag;
      end
   end

   always_ff @(posedge clk) begin
      if (data_we) begin
         data_mem[{wr_index, wr_word}] <= wr_data;
      end
   end

   assign rd_valid = valid_reg[rd_index];
   assign rd_tag   = tag_mem[rd_index];
   assign rd_data  = data_mem[{rd_index, rd_offset}];

endmodule

// File: rtl/icache.sv
// Direct-mapped blocking instruction cache: combinational hit path, one outstanding
// line fill of four beats; flushes during a fill leave the filled line invalid.
module icache
   import icache_pkg::*;
#(
   parameter int LINES = 64,
   parameter int WORDS = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [ADDR_W-1:0]  pc,
   input  logic               en,
   input  logic               flush,
   output logic [INSTR_W-1:0] instr,
   output logic               cache_stall,
   icache_if.master           bus
);

   localparam int IDX_W  = $clog2(LINES);
   localparam int TAG_WD = ADDR_W - LINE_LSB - IDX_W;

   state_t            state_reg, state_next;
   logic [1:0]        beat_reg, beat_next;
   logic [ADDR_W-1:0] miss_addr_reg, miss_addr_next;
   logic              flush_pending_reg, flush_pending_next;

   logic              rd_valid;
   logic [TAG_WD-1:0] rd_tag;
   logic              hit;
   logic              data_we;
   logic              tag_we;
   logic              set_valid;
   logic              unused_pc_bits;

   wire [IDX_W-1:0]  pc_index   = pc[LINE_LSB +: IDX_W];
   wire [TAG_WD-1:0] pc_tag     = pc[ADDR_W-1 -: TAG_WD];
   wire [1:0]        pc_offset  = pc[3:2];
   wire [IDX_W-1:0]  miss_index = miss_addr_reg[LINE_LSB +: IDX_W];
   wire [TAG_WD-1:0] miss_tag   = miss_addr_reg[ADDR_W-1 -: TAG_WD];

   assign unused_pc_bits = ^pc[1:0];

   icache_array #(
      .LINES   (LINES),
      .WORDS_P (WORDS),
      .IDX_W   (IDX_W),
      .TAG_WD  (TAG_WD)
   ) u_array (
      .clk       (clk),
      .rst       (rst),
      .rd_index  (pc_index),
      .rd_offset (pc_offset),
      .rd_valid  (rd_valid),
      .rd_tag    (rd_tag),
      .rd_data   (instr),
      .clear_all (flush),
      .wr_index  (miss_index),
      .data_we   (data_we),
      .wr_word   (beat_reg),
      .wr_data   (bus.mem_rdata),
      .tag_we    (tag_we),
      .wr_tag    (miss_tag),
      .set_valid (set_valid)
   );

   assign hit         = (state_reg == ST_IDLE) && en && rd_valid && (rd_tag == pc_tag);
   assign cache_stall = ((state_reg == ST_IDLE) && en && !hit) || (state_reg != ST_IDLE);

   assign bus.mem_req  = (state_reg == ST_REQ);
   assign bus.mem_addr = miss_addr_reg;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg         <= ST_IDLE;
         beat_reg          <= 2'd0;
         miss_addr_reg     <= '0;
         flush_pending_reg <= 1'b0;
      end else begin
         state_reg         <= state_next;
         beat_reg          <= beat_next;
         miss_addr_reg     <= miss_addr_next;
         flush_pending_reg <= flush_pending_next;
      end
   end

   always_comb begin
      state_next     = state_reg;
      beat_next      = beat_reg;
      miss_addr_next = miss_addr_reg;
      data_we        = 1'b0;
      tag_we         = 1'b0;
      set_valid      = 1'b0;
      case (state_reg)
         ST_IDLE: begin
            if (en && !hit) begin
               state_next     = ST_REQ;
               miss_addr_next = line_align(pc);
               beat_next      = 2'd0;
            end
         end
         ST_REQ: begin
            if (bus.mem_gnt) begin
               state_next = ST_FILL;
            end
         end
         ST_FILL: begin
            if (bus.mem_rvalid) begin
               data_we   = 1'b1;
               beat_next = beat_reg + 2'd1;
               if (beat_reg == 2'd3) begin
                  state_next = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            tag_we     = 1'b1;
            set_valid  = !flush_pending_reg && !flush;
            state_next = ST_IDLE;
         end
         default: state_next = ST_IDLE;
      endcase
   end

   // Pending flag only matters until the line in flight has been written back.
   always_comb begin
      flush_pending_next = flush_pending_reg;
      if (state_reg == ST_DONE) begin
         flush_pending_next = 1'b0;
      end else if (flush && (state_reg != ST_IDLE)) begin
         flush_pending_next = 1'b1;
      end
   end

endmodule
